// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - OAM DMA engine: copies LEN bytes from a source page into OAM; optional OAM_DMA_ECHO_FOLD_EN folds echo pages E0-FF onto C0-DF
module oam_dma #(
  parameter logic [15:0] REG_ADDR = 16'hff46,
  parameter int unsigned LEN      = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write,
  output logic [7:0]  reg_rdata,
  output logic [15:0] src_addr,
  output logic        src_read,
  input  logic [7:0]  src_data,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_write,
  output logic        active
);

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

  state_t     state, state_next;
  logic [7:0] page;
  logic [7:0] src_page;
  logic [7:0] idx, idx_next;
  logic       reg_wr;

  assign reg_wr    = cpu_write && (cpu_addr == REG_ADDR);
  assign reg_rdata = page;
  assign active    = (state != IDLE);

`ifdef OAM_DMA_ECHO_FOLD_EN
  assign src_page = (page >= 8'he0) ? (page - 8'h20) : page;
`else
  assign src_page = page;
`endif

  // State, byte index and page register; a register write always reloads the page.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 8'h00;
      page  <= 8'h00;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (reg_wr) begin
        page <= cpu_wdata;
      end
    end
  end

  // Next state and bus strobes; address/data outputs are held at zero unless strobed.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    src_read   = 1'b0;
    src_addr   = 16'h0000;
    oam_write  = 1'b0;
    oam_addr   = 8'h00;
    oam_wdata  = 8'h00;
    if (reg_wr) begin
      // A register write restarts from any state and wins over step and a pending OAM write.
      state_next = START;
      idx_next   = 8'h00;
    end else begin
      case (state)
        IDLE: begin
        end
        START: begin
          if (step) begin
            state_next = READ;
          end
        end
        READ: begin
          if (step) begin
            src_read   = 1'b1;
            src_addr   = {src_page, idx};
            state_next = WRITE;
          end
        end
        WRITE: begin
          // Source data arrives one clk after the read, so it is forwarded straight to OAM.
          oam_write = 1'b1;
          oam_addr  = idx;
          oam_wdata = src_data;
          if (idx == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            idx_next   = idx + 8'd1;
            state_next = READ;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - randomized self-checking bench for oam_dma against a step-counting transfer model
module tb_oam_dma;

  localparam int          LEN = 160;
  localparam logic [15:0] REG = 16'hff46;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic [7:0]  reg_rdata;
  logic [15:0] src_addr;
  logic        src_read;
  logic [7:0]  src_data = 8'h00;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_write;
  logic        active;

  oam_dma #(.REG_ADDR(REG), .LEN(LEN)) dut (
    .clk(clk), .rst(rst), .step(step),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
    .reg_rdata(reg_rdata),
    .src_addr(src_addr), .src_read(src_read), .src_data(src_data),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_write(oam_write),
    .active(active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Source memory content: chosen so page C1 returns its low address byte.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hc1;
  endfunction

  function automatic logic [7:0] fold(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_FOLD_EN
    return (p >= 8'he0) ? p - 8'h20 : p;
`else
    return p;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Registered source with a one-clk read latency.
  always @(posedge clk) src_data <= src_read ? mem_val(src_addr) : 8'h00;

  // Model: counts accepted steps since the last register write.
  bit         chk_en = 0;
  bit         m_active = 0, m_pend = 0;
  int         m_steps = 0;
  logic [7:0] m_page = 8'h00, m_pidx = 8'h00;
  logic [7:0] dut_oam [256];
  logic [7:0] model_oam [256];

  // Observations for the stimulus flow.
  bit          obs_rd, obs_active;
  logic [15:0] obs_addr;
  logic [7:0]  obs_reg;
  bit          obs_oamw;
  int          st_cnt = 0, first_rd_steps = 0, early_wr = 0, act_steps = 0;
  bit          first_seen = 0, prev_active = 0;
  logic [15:0] first_rd_addr = 16'h0, last_rd_addr = 16'h0;
  int          active_falls = 0, oam_wr_total = 0;

  // Compare DUT outputs with the model mid-cycle, then advance the model for the coming edge.
  always @(negedge clk) begin
    bit          wr, e_rd, e_ow;
    logic [15:0] e_addr;
    logic [7:0]  e_oa, e_od;
    if (chk_en) begin
      wr     = cpu_write && (cpu_addr == REG);
      e_ow   = m_pend && !wr;
      e_rd   = m_active && !m_pend && !wr && step && (m_steps >= 1);
      e_addr = e_rd ? {fold(m_page), 8'(m_steps - 1)} : 16'h0000;
      e_oa   = e_ow ? m_pidx : 8'h00;
      e_od   = e_ow ? mem_val({fold(m_page), m_pidx}) : 8'h00;
      check("active",    {15'd0, active},    {15'd0, m_active});
      check("src_read",  {15'd0, src_read},  {15'd0, e_rd});
      check("src_addr",  src_addr,           e_addr);
      check("oam_write", {15'd0, oam_write}, {15'd0, e_ow});
      check("oam_addr",  {8'd0, oam_addr},   {8'd0, e_oa});
      check("oam_wdata", {8'd0, oam_wdata},  {8'd0, e_od});
      check("reg_rdata", {8'd0, reg_rdata},  {8'd0, m_page});
      if (e_ow) model_oam[e_oa] = e_od;
      if (oam_write) begin
        dut_oam[oam_addr] = oam_wdata;
        oam_wr_total++;
      end

      obs_rd = src_read; obs_addr = src_addr; obs_active = active;
      obs_reg = reg_rdata; obs_oamw = oam_write;
      if (prev_active && !active) active_falls++;
      prev_active = active;
      if (wr) begin
        st_cnt = 0; first_seen = 0; early_wr = 0; act_steps = 0;
      end else begin
        if (step) st_cnt++;
        if (step && active) act_steps++;
        if (oam_write && !first_seen) early_wr++;
        if (src_read) begin
          if (!first_seen) begin
            first_seen = 1; first_rd_steps = st_cnt; first_rd_addr = src_addr;
          end
          last_rd_addr = src_addr;
        end
      end

      if (rst) begin
        m_active = 0; m_pend = 0; m_steps = 0; m_page = 8'h00;
      end else if (wr) begin
        m_active = 1; m_pend = 0; m_steps = 0; m_page = cpu_wdata;
      end else if (m_pend) begin
        m_pend = 0;
        if (m_pidx == 8'(LEN - 1)) m_active = 0;
      end else if (m_active && step) begin
        if (m_steps == 0) m_steps = 1;
        else begin
          m_pend = 1; m_pidx = 8'(m_steps - 1); m_steps++;
        end
      end
    end
  end

  // Stimulus
  int  gap_cnt = 0;
  bit  fixed_gap = 1;
  bit  noise_en = 0;

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    if (gap_cnt == 0) begin
      step = 1'b1;
      gap_cnt = fixed_gap ? 3 : $urandom_range(1, 4);
    end else begin
      step = 1'b0;
      gap_cnt--;
    end
    if (noise_en && $urandom_range(0, 7) == 0) begin
      cpu_write = 1'b1;
      cpu_wdata = 8'($urandom);
      case ($urandom_range(0, 3))
        0: cpu_addr = 16'hff45;
        1: cpu_addr = 16'hff47;
        2: cpu_addr = 16'h0046;
        default: cpu_addr = 16'h7f46;
      endcase
    end
  endtask

  task automatic do_write(input logic [7:0] d);
    tick();
    cpu_write = 1'b1; cpu_addr = REG; cpu_wdata = d;
  endtask

  task automatic wait_done();
    tick(); tick();
    for (int n = 0; n < 4000; n++) begin
      if (!obs_active) return;
      tick();
    end
    errors++;
    $display("FAIL wait_done: active still high after 4000 cycles (cycle %0d)", cyc);
  endtask

  task automatic wait_read_low(input logic [7:0] low);
    for (int n = 0; n < 4000; n++) begin
      tick();
      if (obs_rd && obs_addr[7:0] == low) return;
    end
    errors++;
    $display("FAIL wait_read: no read of index %0d within 4000 cycles (cycle %0d)", low, cyc);
  endtask

  task automatic wait_first_read();
    for (int n = 0; n < 200; n++) begin
      tick();
      if (obs_rd) return;
    end
    errors++;
    $display("FAIL wait_first_read: no read within 200 cycles (cycle %0d)", cyc);
  endtask

  initial begin
    int falls0, wr0;
    for (int i = 0; i < 256; i++) begin
      dut_oam[i] = 8'h00; model_oam[i] = 8'h00;
    end
    rst = 1'b1; step = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;
    tick();
    check("reset_active",   {15'd0, obs_active}, 16'd0);
    check("reset_reg",      {8'd0, obs_reg},     16'h0000);
    check("reset_src_read", {15'd0, obs_rd},     16'd0);
    check("reset_src_addr", obs_addr,            16'h0000);
    check("reset_oam_write",{15'd0, obs_oamw},   16'd0);

    // Full transfer of page C1, step every 4 clk.
    do_write(8'hc1);
    wait_done();
    check("c1_first_read_step", 16'(first_rd_steps), 16'd2);
    check("c1_early_writes",    16'(early_wr),       16'd0);
    check("c1_first_addr",      first_rd_addr,       16'hc100);
    check("c1_last_addr",       last_rd_addr,        16'hc19f);
    check("c1_active_steps",    16'(act_steps),      16'd161);
    for (int i = 0; i < LEN; i++) check("c1_oam", {8'd0, dut_oam[i]}, 16'(i));

    // Restart with page C2 during the write cycle of index 50.
    fixed_gap = 0;
    do_write(8'hc5);
    falls0 = active_falls;
    wait_read_low(8'd50);
    cpu_write = 1'b1; cpu_addr = REG; cpu_wdata = 8'hc2;
    wait_done();
    check("restart_first_addr", first_rd_addr,               16'hc200);
    check("restart_falls",      16'(active_falls - falls0),  16'd1);
    for (int i = 0; i < LEN; i++) check("restart_oam", {8'd0, dut_oam[i]}, 16'(i ^ 3));

    // Echo page E3, then reset mid-transfer at index 80.
    do_write(8'he3);
    wait_first_read();
`ifdef OAM_DMA_ECHO_FOLD_EN
    check("echo_first_addr", obs_addr, 16'hc300);
`else
    check("echo_first_addr", obs_addr, 16'he300);
`endif
    check("echo_reg", {8'd0, obs_reg}, 16'h00e3);
    wait_read_low(8'd80);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("abort_active",    {15'd0, obs_active}, 16'd0);
    check("abort_src_read",  {15'd0, obs_rd},     16'd0);
    check("abort_oam_write", {15'd0, obs_oamw},   16'd0);
    check("abort_reg",       {8'd0, obs_reg},     16'h0000);
    wr0 = oam_wr_total;
    for (int n = 0; n < 40; n++) tick();
    check("abort_no_writes", 16'(oam_wr_total - wr0), 16'd0);

    // Register write coinciding with step.
    for (int n = 0; n < 10; n++) begin
      tick();
      if (step) break;
    end
    cpu_write = 1'b1; cpu_addr = REG; cpu_wdata = 8'hd0;
    wait_done();
    check("coincide_first_read_step", 16'(first_rd_steps), 16'd2);
    check("coincide_early_writes",    16'(early_wr),       16'd0);

    // Random pages, noise writes and random restarts.
    noise_en = 1;
    for (int it = 0; it < 4; it++) begin
      int wt;
      do_write(8'($urandom_range(8'hc0, 8'hff)));
      wt = $urandom_range(10, 900);
      for (int n = 0; n < wt; n++) tick();
      if (obs_active && $urandom_range(0, 1) == 1) do_write(8'($urandom));
      wait_done();
    end
    noise_en = 0;
    tick();
    for (int i = 0; i < LEN; i++) check("final_oam", {8'd0, dut_oam[i]}, {8'd0, model_oam[i]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
